// File: rtl/cipher_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin cipher arbiter.
// Holds the FSM state encoding and the grant-index width function.
package cipher_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // A single requester still needs a one-bit index.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cipher_rr_arbiter_picker.sv
// Combinational round-robin selector: picks the first set request bit
// starting just after last_grant and wrapping modulo N.
module rr_priority_picker
  import cipher_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = grant_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_grant_i,
  output logic         found_o,
  output logic [W-1:0] grant_o
);

  logic [W-1:0] cand_idx [N];

  // cand_idx[k] is the requester with the k-th highest priority this cycle.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand_idx[gi] = W'((int'(last_grant_i) + 1 + gi) % N);
    end
  endgenerate

  always_comb begin
    found_o = 1'b0;
    grant_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[cand_idx[k]]) begin
        found_o = 1'b1;
        grant_o = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/cipher_rr_arbiter.sv
// Round-robin arbiter sharing one start/done block cipher among NUM_REQ
// requesters, with a watchdog that answers with an error if the core hangs.
module cipher_rr_arbiter
  import cipher_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BLOCK_SIZE     = 64,
  parameter int KEY_SIZE       = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*BLOCK_SIZE-1:0]  req_data_i,
  input  logic [NUM_REQ*KEY_SIZE-1:0]    req_key_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [BLOCK_SIZE-1:0]          rsp_data_o,
  output logic                           rsp_err_o,
  output logic                           core_start_o,
  output logic [KEY_SIZE-1:0]            core_key_o,
  output logic [BLOCK_SIZE-1:0]          core_plaintext_o,
  input  logic [BLOCK_SIZE-1:0]          core_ciphertext_i,
  input  logic                           core_done_i,
  output logic                           busy_o,
  output logic [grant_width(NUM_REQ)-1:0] grant_id_o
);

  localparam int GW = grant_width(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t            state_q, state_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [KEY_SIZE-1:0]   core_key_q, core_key_d;
  logic [BLOCK_SIZE-1:0] core_pt_q, core_pt_d;
  logic [BLOCK_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CW-1:0]         wd_cnt_q, wd_cnt_d;

  logic [BLOCK_SIZE-1:0] data_arr [NUM_REQ];
  logic [KEY_SIZE-1:0]   key_arr  [NUM_REQ];
  logic                  found;
  logic [GW-1:0]         pick;
  logic                  accept;

  rr_priority_picker #(
    .N (NUM_REQ),
    .W (GW)
  ) u_picker (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .found_o      (found),
    .grant_o      (pick)
  );

  assign accept = (state_q == IDLE) && found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
      assign data_arr[gi]    = req_data_i[gi*BLOCK_SIZE +: BLOCK_SIZE];
      assign key_arr[gi]     = req_key_i[gi*KEY_SIZE +: KEY_SIZE];
      assign req_ready_o[gi] = accept && (pick == GW'(gi));
      assign rsp_valid_o[gi] = (state_q == RESP) && (grant_id_q == GW'(gi));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    core_key_d   = core_key_q;
    core_pt_d    = core_pt_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    wd_cnt_d     = wd_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          core_pt_d  = data_arr[pick];
          core_key_d = key_arr[pick];
          grant_id_d = pick;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        // A completion on the last allowed cycle still counts as success.
        if (core_done_i) begin
          rsp_data_d = core_ciphertext_i;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wd_cnt_q == WD_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i[grant_id_q]) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      core_key_q   <= '0;
      core_pt_q    <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      core_key_q   <= core_key_d;
      core_pt_q    <= core_pt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign core_start_o     = (state_q == ISSUE);
  assign busy_o           = (state_q != IDLE);
  assign grant_id_o       = grant_id_q;
  assign core_key_o       = core_key_q;
  assign core_plaintext_o = core_pt_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_err_o        = rsp_err_q;

endmodule

// File: tb/tb_cipher_rr_arbiter.sv
// Directed bench for cipher_rr_arbiter with a behavioural cipher core whose
// latency (or hang) is set per step; expected values come from a local model.
module tb_cipher_rr_arbiter;

  localparam int NR = 4;
  localparam int BS = 64;
  localparam int KS = 64;
  localparam int TO = 16;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*BS-1:0]  req_data;
  logic [NR*KS-1:0]  req_key;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [BS-1:0]     rsp_data;
  logic              rsp_err;
  logic              core_start;
  logic [KS-1:0]     core_key;
  logic [BS-1:0]     core_plaintext;
  logic [BS-1:0]     core_ct = '0;
  logic              core_done = 1'b0;
  logic              busy;
  logic [1:0]        grant_id;

  int checks = 0;
  int failures = 0;
  int core_lat = 4;
  bit core_hang = 1'b0;
  int core_cnt = 0;

  logic [63:0] pt [NR];
  logic [63:0] ky [NR];

  cipher_rr_arbiter #(
    .NUM_REQ        (NR),
    .BLOCK_SIZE     (BS),
    .KEY_SIZE       (KS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_data_i        (req_data),
    .req_key_i         (req_key),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_data_o        (rsp_data),
    .rsp_err_o         (rsp_err),
    .core_start_o      (core_start),
    .core_key_o        (core_key),
    .core_plaintext_o  (core_plaintext),
    .core_ciphertext_i (core_ct),
    .core_done_i       (core_done),
    .busy_o            (busy),
    .grant_id_o        (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [63:0] p, input logic [63:0] k);
    return {p[31:0] ^ k[63:32], p[63:32] ^ k[31:0]} + 64'h9E3779B97F4A7C15;
  endfunction

  // Core model: done pulses core_lat cycles after the start cycle, never if hung.
  always @(negedge clk) begin
    if (reset) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else if (core_start) begin
      core_cnt  <= core_hang ? 0 : core_lat;
      core_done <= 1'b0;
    end else if (core_cnt == 1) begin
      core_cnt  <= 0;
      core_done <= 1'b1;
      core_ct   <= model(core_plaintext, core_key);
    end else begin
      if (core_cnt > 1) core_cnt <= core_cnt - 1;
      core_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until any rsp_valid bit rises, bounded at 200.
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic release_rsp(input logic [NR-1:0] r);
    rsp_ready = r;
    @(negedge clk);
    #1;
    rsp_ready = '0;
    chk("release_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    pt[0] = 64'h0123456789ABCDEF;
    ky[0] = 64'h0F0E0D0C0B0A0908;
    for (int i = 1; i < NR; i++) begin
      pt[i] = 64'h0011223344556677 + 64'(i) * 64'h0101010101010101;
      ky[i] = 64'hF0E1D2C3B4A59687 ^ (64'(i) << 8);
    end
    for (int i = 0; i < NR; i++) begin
      req_data[i*BS +: BS] = pt[i];
      req_key[i*KS +: KS]  = ky[i];
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_req_ready",  64'(req_ready),  64'd0);
    chk("rst_rsp_valid",  64'(rsp_valid),  64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_grant_id",   64'(grant_id),   64'd0);
    chk("rst_rsp_data",   rsp_data,        64'd0);
    chk("rst_rsp_err",    64'(rsp_err),    64'd0);
    chk("rst_core_pt",    core_plaintext,  64'd0);
    reset = 1'b0;

    // Single request from requester 0, core latency 10.
    @(negedge clk);
    core_lat  = 10;
    req_valid = 4'b0001;
    #1;
    chk("single_req_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single_start",     64'(core_start), 64'd1);
    chk("single_grant",     64'(grant_id),   64'd0);
    chk("single_core_pt",   core_plaintext,  pt[0]);
    chk("single_core_key",  core_key,        ky[0]);
    wait_rsp(n);
    chk("single_latency",   64'(n),          64'd11);
    chk("single_rsp_valid", 64'(rsp_valid),  64'h1);
    chk("single_rsp_data",  rsp_data,        model(pt[0], ky[0]));
    chk("single_rsp_err",   64'(rsp_err),    64'd0);
    release_rsp(4'b0001);
    chk("single_rsp_clear", 64'(rsp_valid),  64'd0);

    // Reset so the round-robin sweep starts from requester 0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    core_lat  = 2;
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    for (int t = 0; t < 8; t++) begin
      #1;
      chk("rr_req_ready", 64'(req_ready), 64'(1) << (t % NR));
      @(negedge clk);
      #1;
      chk("rr_grant", 64'(grant_id),   64'(t % NR));
      chk("rr_start", 64'(core_start), 64'd1);
      wait_rsp(n);
      chk("rr_latency",   64'(n),         64'd3);
      chk("rr_rsp_valid", 64'(rsp_valid), 64'(1) << (t % NR));
      chk("rr_rsp_data",  rsp_data,       model(pt[t % NR], ky[t % NR]));
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = '0;

    // Back-pressure on requester 2; other rsp_ready bits must be ignored.
    core_lat  = 3;
    req_valid = 4'b0100;
    #1;
    chk("bp_req_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    req_valid = 4'hF;
    wait_rsp(n);
    chk("bp_latency", 64'(n), 64'd4);
    rsp_ready = 4'b1011;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h4);
      chk("bp_rsp_data",  rsp_data,       model(pt[2], ky[2]));
      chk("bp_no_ready",  64'(req_ready), 64'd0);
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    #1;
    rsp_ready = '0;
    chk("bp_release_busy", 64'(busy),      64'd0);
    chk("bp_next_ready",   64'(req_ready), 64'h8);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("bp_drop_busy", 64'(busy), 64'd0);

    // Watchdog: hung core on requester 1.
    core_hang = 1'b1;
    req_valid = 4'b0010;
    #1;
    chk("wd_req_ready", 64'(req_ready), 64'h2);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("wd_start", 64'(core_start), 64'd1);
    wait_rsp(n);
    chk("wd_latency",   64'(n),         64'd17);
    chk("wd_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("wd_rsp_err",   64'(rsp_err),   64'd1);
    chk("wd_rsp_data",  rsp_data,       64'd0);
    release_rsp(4'b0010);

    // Normal transaction after the timeout.
    core_hang = 1'b0;
    core_lat  = 3;
    req_valid = 4'b0010;
    #1;
    chk("wd2_req_ready", 64'(req_ready), 64'h2);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n);
    chk("wd2_latency",  64'(n),       64'd4);
    chk("wd2_rsp_err",  64'(rsp_err), 64'd0);
    chk("wd2_rsp_data", rsp_data,     model(pt[1], ky[1]));
    release_rsp(4'b0010);

    // Done on the final WAIT cycle collides with the timeout.
    core_lat  = TO;
    req_valid = 4'b1000;
    #1;
    chk("sim_req_ready", 64'(req_ready), 64'h8);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n);
    chk("sim_latency",   64'(n),         64'd17);
    chk("sim_rsp_valid", 64'(rsp_valid), 64'h8);
    chk("sim_rsp_err",   64'(rsp_err),   64'd0);
    chk("sim_rsp_data",  rsp_data,       model(pt[3], ky[3]));
    release_rsp(4'b1000);

    // Reset while requester 2 is waiting on the core.
    core_lat  = 10;
    req_valid = 4'b0100;
    #1;
    chk("rw_req_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rw_busy",       64'(busy),       64'd0);
    chk("rw_core_start", 64'(core_start), 64'd0);
    chk("rw_rsp_valid",  64'(rsp_valid),  64'd0);
    chk("rw_grant_id",   64'(grant_id),   64'd0);
    chk("rw_rsp_data",   rsp_data,        64'd0);
    chk("rw_core_pt",    core_plaintext,  64'd0);
    chk("rw_core_key",   core_key,        64'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    #1;
    chk("rw_no_rsp", 64'(seen), 64'd0);
    req_valid = 4'hF;
    #1;
    chk("rw_restart_ready", 64'(req_ready), 64'h1);
    req_valid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cipher_rr_arbiter.md
Name: cipher_rr_arbiter

Overview:
- Shares one gage_ingage_cipher core (start/done interface) among NUM_REQ requesters using round-robin arbitration.
- Each requester submits one plaintext block and key over a valid/ready handshake. It receives the ciphertext on its own response channel.
- Sits between multi-channel crypto clients (ECB/CBC sequencers, DMA) and the single block cipher instance.
- Adds a watchdog so a hung core cannot deadlock the clients.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- BLOCK_SIZE, 64, cipher block width in bits.
- KEY_SIZE, 64, key width in bits.
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before the watchdog fires (≥2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept
- req_data  in  NUM_REQ*BLOCK_SIZE  plaintext; requester i at slice [i*BLOCK_SIZE +: BLOCK_SIZE]
- req_key  in  NUM_REQ*KEY_SIZE  key; requester i at slice [i*KEY_SIZE +: KEY_SIZE]
- rsp_valid  out  NUM_REQ  per-requester response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  BLOCK_SIZE  ciphertext, shared by all requesters, qualified by rsp_valid
- rsp_err  out  1  response is a watchdog timeout; rsp_data=0
- core_start  out  1  one-cycle start pulse to the cipher
- core_key  out  KEY_SIZE  registered key to the cipher
- core_plaintext  out  BLOCK_SIZE  registered plaintext to the cipher
- core_ciphertext  in  BLOCK_SIZE  cipher result
- core_done  in  1  cipher completion pulse
- busy  out  1  state != IDLE
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester

Behaviour:
- Reset values:
  - All outputs 0.
  - last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
  - State IDLE.
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - The search for the lowest-cost valid requester starts at last_grant+1 and wraps modulo NUM_REQ.
  - req_ready[g] is combinational: high only in IDLE, only for the selected g, and only while req_valid[g]=1. At most one req_ready bit is high.
  - On acceptance, register req_data/req_key slice g into core_plaintext/core_key, set grant_id=g, and go to ISSUE.
- ISSUE:
  - core_start=1 for exactly one cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT:
  - core_plaintext/core_key stay stable.
  - If core_done: capture core_ciphertext into rsp_data, set rsp_err=0, go to RESP.
  - Else, when the counter reaches TIMEOUT_CYCLES-1: set rsp_data=0, rsp_err=1, go to RESP.
  - If core_done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid[grant_id]=1; other bits stay 0.
  - rsp_valid holds until rsp_ready[grant_id]=1.
  - On that cycle: last_grant ← grant_id, rsp_valid cleared, go to IDLE.
  - rsp_ready on non-granted bits is ignored.
- Latency: accept → core_start is 1 cycle. core_done → rsp_valid is 1 cycle.
- Minimum turnaround per block is 3 cycles plus core latency (RESP with immediate rsp_ready).
- Fairness: with all requesters continuously valid, grants are strictly 0,1,2,…,NUM_REQ-1,0,…
- A requester cannot be accepted again until its prior response has completed (single outstanding transaction globally).
- core_done outside WAIT is ignored.
- req_valid may drop before acceptance without consequence. The block does not require AXI-style stickiness.
- Reset mid-operation aborts everything immediately: the in-flight block is lost and no response is produced. The core shares the same reset.

Decomposition:
- Package cipher_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - the grant-index width function (clog2).
- Sub-module rr_priority_picker: a combinational round-robin selector.
  - Inputs: req vector, last_grant.
  - Outputs: found, grant index.
  - Reusable by future multi-core schedulers.

Test Plan:
- Single request: req0 data=0x0123456789ABCDEF, key=0x0F0E0D0C0B0A0908, core model done after 10 cycles → core_start one cycle after accept; rsp_valid[0] with the model ciphertext; rsp_err=0.
- All 4 requesters valid continuously, 8 transactions → grant order 0,1,2,3,0,1,2,3; each rsp_valid goes only to the matching bit.
- Back-pressure: rsp_ready[2] held low for 20 cycles → rsp_valid[2] and rsp_data stable; no new req_ready during the stall; release → IDLE next cycle.
- Watchdog: core never asserts done, TIMEOUT_CYCLES=16 → rsp_valid after exactly 16 WAIT cycles with rsp_err=1, rsp_data=0; next request proceeds normally.
- Simultaneous core_done and timeout on the final WAIT cycle → rsp_err=0 and ciphertext delivered.
- Reset asserted during WAIT → all outputs 0 on reset, grant restarts at requester 0, and the aborted requester gets no response.
